// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet-locking round-robin stream multiplexer.
package stream_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_STREAMS = 16;

    // Width of a stream index; never narrower than one bit so N=1 still has a port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned MAX_IDX_W = idx_width(MAX_STREAMS);

endpackage

// File: rtl/stream_arb_mux_if.sv
// Bundle of the N input streams, the merged output stream and the lock status.
interface stream_arb_mux_if
    import stream_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
) ();

    localparam int unsigned IW = idx_width(N);

    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [IW-1:0]  out_src;
    logic           busy;

    // Source side: drives the input streams and the downstream ready.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src, busy
    );

    // Multiplexer side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src, busy
    );

endinterface

// File: rtl/stream_reg_slice.sv
// Two-entry skid buffer: full throughput with registered outputs and a registered ready.
module stream_reg_slice #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    logic          main_valid;
    logic [PW-1:0] main_data;
    logic          skid_valid;
    logic [PW-1:0] skid_data;

    // Ready only depends on the skid entry, so it never combinationally follows out_ready.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!main_valid || out_ready) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_valid;
                if (in_valid) begin
                    main_data <= in_data;
                end
            end
        end else if (in_valid && !skid_valid) begin
            // Output stalled: park the incoming beat in the skid entry.
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// Round-robin N:1 stream multiplexer that locks onto one source for a whole packet
// and feeds the winner's beats through a two-entry output skid buffer.
module stream_arb_mux
    import stream_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst,
    stream_arb_mux_if.slave bus
);

    localparam int unsigned IW = idx_width(N);
    localparam int unsigned PW = W + 1 + IW;

    arb_state_e    state;
    arb_state_e    state_next;
    logic [IW-1:0] winner;
    logic [IW-1:0] winner_next;
    logic [IW-1:0] last_winner;
    logic [IW-1:0] last_winner_next;

    logic [N-1:0]  valid_idle_c;
    logic [N-1:0]  rot_c;
    logic [IW-1:0] start_c;
    logic [IW:0]   offset_c;
    logic [IW:0]   sum_c;
    logic [IW-1:0] pick_c;
    logic          pick_valid_c;

    logic          sel_valid_c;
    logic          sel_last_c;
    logic [W-1:0]  sel_data_c;
    logic [N-1:0]  in_ready_c;
    logic          push_c;

    logic          slice_ready;
    logic          slice_valid;
    logic [PW-1:0] slice_out;

    // Round-robin pick: rotate requests so the search starts after the last winner,
    // take the lowest set bit, then rotate the index back. Requests are masked outside IDLE.
    always_comb begin
        valid_idle_c = (state == IDLE) ? bus.in_valid : '0;
        start_c      = (last_winner == IW'(N - 1)) ? '0 : last_winner + IW'(1);
        rot_c        = N'({valid_idle_c, valid_idle_c} >> start_c);
        pick_valid_c = 1'b0;
        offset_c     = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (rot_c[k]) begin
                pick_valid_c = 1'b1;
                offset_c     = (IW + 1)'(k);
            end
        end
        sum_c = {1'b0, start_c} + offset_c;
        if (sum_c >= (IW + 1)'(N)) begin
            sum_c = sum_c - (IW + 1)'(N);
        end
        pick_c = sum_c[IW-1:0];
    end

    // Route the locked stream's beat toward the output slice.
    always_comb begin
        sel_valid_c = 1'b0;
        sel_last_c  = 1'b0;
        sel_data_c  = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (winner == IW'(k)) begin
                sel_valid_c = bus.in_valid[k];
                sel_last_c  = bus.in_last[k];
                sel_data_c  = bus.in_data[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            winner      <= '0;
            last_winner <= IW'(N - 1);
        end else begin
            state       <= state_next;
            winner      <= winner_next;
            last_winner <= last_winner_next;
        end
    end

    always_comb begin
        state_next       = state;
        winner_next      = winner;
        last_winner_next = last_winner;
        in_ready_c       = '0;
        push_c           = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid_c) begin
                    winner_next = pick_c;
                    state_next  = LOCKED;
                end
            end
            LOCKED: begin
                for (int k = 0; k < int'(N); k++) begin
                    if (winner == IW'(k)) begin
                        in_ready_c[k] = slice_ready;
                    end
                end
                push_c = sel_valid_c & slice_ready;
                // The final beat releases the lock on the same edge it is accepted.
                if (push_c && sel_last_c) begin
                    state_next       = IDLE;
                    last_winner_next = winner;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    stream_reg_slice #(
        .PW(PW)
    ) u_slice (
        .clk      (clk),
        .rst      (rst),
        .in_valid (push_c),
        .in_ready (slice_ready),
        .in_data  ({sel_last_c, winner, sel_data_c}),
        .out_valid(slice_valid),
        .out_ready(bus.out_ready),
        .out_data (slice_out)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = slice_valid;
    assign bus.out_data  = slice_out[W-1:0];
    assign bus.out_src   = slice_out[W +: IW];
    assign bus.out_last  = slice_out[PW-1];
    assign bus.busy      = (state == LOCKED);

endmodule

// File: tb/tb_stream_arb_mux.sv
// Scoreboard bench for stream_arb_mux: a 4-stream instance for arbitration and
// stall behaviour, and a 1-stream 8-bit instance for the degenerate case.
module tb_stream_arb_mux;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0]  src;
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stream_arb_mux_if #(.N(4), .W(32)) bus ();
    stream_arb_mux_if #(.N(1), .W(8))  bus1 ();

    stream_arb_mux #(.N(4), .W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    stream_arb_mux #(.N(1), .W(8))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    beat_t       src_q [4][$];
    exp_t        sb [$];
    int          obs_src [$];
    logic [31:0] obs_data [$];
    int          obs_cyc [$];
    int          acc_cnt [4];
    logic [3:0]  hold;
    bit          rand_ready;
    bit          rand_hold;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [1:0]  prev_src;
    bit          in_pkt;
    logic [1:0]  pkt_src;

    function automatic beat_t mk_beat(input logic last, input logic [31:0] data);
        beat_t b;
        b.last = last;
        b.data = data;
        return b;
    endfunction

    function automatic bit pending();
        return (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() + sb.size()) != 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_last   = '0;
        bus.out_ready = 1'b1;
        bus1.in_valid  = '0;
        bus1.in_data   = '0;
        bus1.in_last   = '0;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            acc_cnt[i] = 0;
        end
        sb.delete();
        obs_src.delete();
        obs_data.delete();
        obs_cyc.delete();
        hold       = '0;
        rand_ready = 1'b0;
        rand_hold  = 1'b0;
        prev_stall = 1'b0;
        in_pkt     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock per iteration: drive at posedge+1, observe at negedge, retire accepted beats.
    task automatic run_cycles(input int n);
        logic [3:0] v;
        logic [3:0] acc;
        exp_t       e;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 4; i++) begin
                v[i] = (src_q[i].size() != 0) && !hold[i] && !(rand_hold && ($urandom_range(3) == 0));
                bus.in_data[i*32 +: 32] = v[i] ? src_q[i][0].data : 32'h0;
                bus.in_last[i]          = v[i] ? src_q[i][0].last : 1'b0;
            end
            bus.in_valid  = v;
            bus.out_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
            @(negedge clk);
            cyc++;
            checks++;
            if (!$onehot0(bus.in_ready) || (bus.busy !== 1'b1 && bus.in_ready !== 4'b0)) begin
                errors++;
                $display("FAIL in_ready_rule: in_ready=%b busy=%b, required onehot0 and zero when idle", bus.in_ready, bus.busy);
            end
            acc = bus.in_valid & bus.in_ready;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    e.src  = 2'(i);
                    e.last = src_q[i][0].last;
                    e.data = src_q[i][0].data;
                    sb.push_back(e);
                    acc_cnt[i]++;
                end
            end
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_last !== prev_last || bus.out_src !== prev_src) begin
                    errors++;
                    $display("FAIL stall_stable: v=%b d=%h l=%b s=%0d, required v=1 d=%h l=%b s=%0d",
                             bus.out_valid, bus.out_data, bus.out_last, bus.out_src, prev_data, prev_last, prev_src);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            prev_src   = bus.out_src;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got src=%0d data=%h, required no beat", bus.out_src, bus.out_data);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_src !== e.src || bus.out_last !== e.last || bus.out_data !== e.data) begin
                        errors++;
                        $display("FAIL sb_beat: got src=%0d last=%b data=%h, required src=%0d last=%b data=%h",
                                 bus.out_src, bus.out_last, bus.out_data, e.src, e.last, e.data);
                    end
                end
                checks++;
                if (in_pkt && bus.out_src !== pkt_src) begin
                    errors++;
                    $display("FAIL interleave: got src=%0d mid-packet, required src=%0d", bus.out_src, pkt_src);
                end
                in_pkt  = !bus.out_last;
                pkt_src = bus.out_src;
                obs_src.push_back(int'(bus.out_src));
                obs_data.push_back(bus.out_data);
                obs_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) void'(src_q[i].pop_front());
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 8;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b, required 0", bus.out_last); end
        if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h, required 0", bus.out_data); end
        if (bus.out_src !== 2'd0) begin errors++; $display("FAIL rst_out_src: got %0d, required 0", bus.out_src); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
        if (bus.in_ready !== 4'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); end
        if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL rst1_out_valid: got %b, required 0", bus1.out_valid); end
        if (bus1.out_data !== 8'h0) begin errors++; $display("FAIL rst1_out_data: got %h, required 0", bus1.out_data); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) src_q[i].push_back(mk_beat(1'b1, 32'(i * 16 + k)));
        for (int t = 0; t < 60 && obs_src.size() < 8; t++) run_cycles(1);
        checks++;
        if (obs_src.size() != 8) begin
            errors++;
            $display("FAIL rr_count: got %0d beats, required 8", obs_src.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs_src[k] != k % 4) begin
                    errors++;
                    $display("FAIL rr_order: beat %0d src=%0d, required %0d", k, obs_src[k], k % 4);
                end
                if (k > 0) begin
                    checks++;
                    if (obs_cyc[k] - obs_cyc[k-1] != 2) begin
                        errors++;
                        $display("FAIL rr_spacing: beat %0d gap=%0d, required 2", k, obs_cyc[k] - obs_cyc[k-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_locked_packet();
        int exp_src [9] = '{0, 2, 2, 2, 2, 2, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 4; k++) src_q[0].push_back(mk_beat(1'b1, 32'hA0 + 32'(k)));
        for (int k = 0; k < 5; k++) src_q[2].push_back(mk_beat(k == 4, 32'h10 + 32'(k)));
        for (int t = 0; t < 80 && pending(); t++) run_cycles(1);
        checks++;
        if (obs_src.size() != 9) begin
            errors++;
            $display("FAIL lock_count: got %0d beats, required 9", obs_src.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (obs_src[k] != exp_src[k]) begin
                    errors++;
                    $display("FAIL lock_order: beat %0d src=%0d, required %0d", k, obs_src[k], exp_src[k]);
                end
            end
            for (int k = 1; k < 6; k++) begin
                checks += 2;
                if (obs_data[k] !== 32'h10 + 32'(k - 1)) begin
                    errors++;
                    $display("FAIL lock_data: beat %0d data=%h, required %h", k, obs_data[k], 32'h10 + 32'(k - 1));
                end
                if (k > 1 && obs_cyc[k] - obs_cyc[k-1] != 1) begin
                    errors++;
                    $display("FAIL lock_contig: beat %0d gap=%0d, required 1", k, obs_cyc[k] - obs_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_lock_hold();
        int exp_src [5] = '{1, 1, 1, 1, 3};
        do_reset();
        for (int k = 0; k < 4; k++) src_q[1].push_back(mk_beat(k == 3, 32'h20 + 32'(k)));
        src_q[3].push_back(mk_beat(1'b1, 32'h30));
        for (int t = 0; t < 40 && acc_cnt[1] < 2; t++) run_cycles(1);
        hold[1] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            run_cycles(1);
            checks += 2;
            if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_busy: cycle %0d got %b, required 1", t, bus.busy); end
            if (bus.in_ready[3] !== 1'b0) begin errors++; $display("FAIL hold_ready3: cycle %0d got %b, required 0", t, bus.in_ready[3]); end
        end
        hold[1] = 1'b0;
        for (int t = 0; t < 60 && pending(); t++) run_cycles(1);
        checks++;
        if (obs_src.size() != 5) begin
            errors++;
            $display("FAIL hold_count: got %0d beats, required 5", obs_src.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (obs_src[k] != exp_src[k]) begin
                    errors++;
                    $display("FAIL hold_order: beat %0d src=%0d, required %0d", k, obs_src[k], exp_src[k]);
                end
            end
        end
    endtask

    task automatic test_random_stall();
        int n2;
        do_reset();
        rand_ready = 1'b1;
        rand_hold  = 1'b1;
        for (int k = 0; k < 100; k++) src_q[2].push_back(mk_beat((k % 10) == 9, $urandom));
        for (int k = 0; k < 20; k++) src_q[1].push_back(mk_beat((k % 4) == 3, $urandom));
        for (int t = 0; t < 3000 && pending(); t++) run_cycles(1);
        rand_ready = 1'b0;
        rand_hold  = 1'b0;
        n2 = 0;
        foreach (obs_src[k]) if (obs_src[k] == 2) n2++;
        checks += 2;
        if (obs_src.size() != 120) begin
            errors++;
            $display("FAIL rand_total: got %0d beats, required 120", obs_src.size());
        end
        if (n2 != 100) begin
            errors++;
            $display("FAIL rand_stream2: got %0d beats, required 100", n2);
        end
    endtask

    task automatic test_reset_mid();
        int exp_src [4] = '{0, 0, 3, 3};
        do_reset();
        src_q[0].push_back(mk_beat(1'b1, 32'h01));
        for (int k = 0; k < 4; k++) src_q[3].push_back(mk_beat(k == 3, 32'h30 + 32'(k)));
        for (int t = 0; t < 40 && acc_cnt[3] < 2; t++) run_cycles(1);
        rst = 1'b1;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", bus.busy); end
        if (bus.in_ready !== 4'b0) begin errors++; $display("FAIL midrst_in_ready: got %b, required 0", bus.in_ready); end
        do_reset();
        src_q[3].push_back(mk_beat(1'b0, 32'h50));
        src_q[3].push_back(mk_beat(1'b1, 32'h51));
        src_q[0].push_back(mk_beat(1'b0, 32'h40));
        src_q[0].push_back(mk_beat(1'b1, 32'h41));
        for (int t = 0; t < 40 && pending(); t++) run_cycles(1);
        checks++;
        if (obs_src.size() != 4) begin
            errors++;
            $display("FAIL midrst_count: got %0d beats, required 4", obs_src.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_src[k] != exp_src[k]) begin
                    errors++;
                    $display("FAIL midrst_order: beat %0d src=%0d, required %0d", k, obs_src[k], exp_src[k]);
                end
            end
        end
    endtask

    task automatic test_single_stream();
        logic [8:0] q [$];
        logic [8:0] sb8 [$];
        logic [8:0] e;
        bit         accepted;
        int         first = -1;
        int         last_c = -1;
        int         nout = 0;
        do_reset();
        for (int k = 0; k < 6; k++) q.push_back({(k % 2) == 1, 8'h60 + 8'(k)});
        for (int t = 0; t < 40 && nout < 6; t++) begin
            bus1.in_valid[0] = (q.size() != 0);
            bus1.in_last[0]  = (q.size() != 0) ? q[0][8] : 1'b0;
            bus1.in_data     = (q.size() != 0) ? q[0][7:0] : 8'h0;
            @(negedge clk);
            accepted = bus1.in_valid[0] && bus1.in_ready[0];
            if (accepted) sb8.push_back(q[0]);
            if (bus1.out_valid && bus1.out_ready) begin
                checks += 2;
                if (sb8.size() == 0) begin
                    errors++;
                    $display("FAIL n1_extra: got data=%h, required no beat", bus1.out_data);
                end else begin
                    e = sb8.pop_front();
                    if ({bus1.out_last, bus1.out_data} !== e) begin
                        errors++;
                        $display("FAIL n1_beat: got last=%b data=%h, required last=%b data=%h", bus1.out_last, bus1.out_data, e[8], e[7:0]);
                    end
                end
                if (bus1.out_src !== 1'b0) begin
                    errors++;
                    $display("FAIL n1_src: got %0d, required 0", bus1.out_src);
                end
                if (first < 0) first = t;
                last_c = t;
                nout++;
            end
            @(posedge clk);
            #1;
            if (accepted) void'(q.pop_front());
        end
        bus1.in_valid = '0;
        checks += 2;
        if (nout != 6) begin
            errors++;
            $display("FAIL n1_count: got %0d beats, required 6", nout);
        end
        if (last_c - first != 7) begin
            errors++;
            $display("FAIL n1_rate: 6 beats spanned %0d cycles, required 7", last_c - first);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_locked_packet();
        test_lock_hold();
        test_random_stall();
        test_reset_mid();
        test_single_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
